// File: rtl/frame_tracker_pkg.sv
// Shared constants for the frame tracker: grid geometry defaults and the
// 3-bit object codes that the encoder produces for each grid cell.
package frame_tracker_pkg;

  localparam int DEFAULT_GRID_W  = 16;
  localparam int DEFAULT_GRID_H  = 12;
  localparam int DEFAULT_COORD_W = 4;
  localparam int CODE_W          = 3;

  typedef logic [CODE_W-1:0] obj_code_t;

  localparam obj_code_t OBJ_EMPTY  = 3'b000;
  localparam obj_code_t OBJ_HEAD   = 3'b001;
  localparam obj_code_t OBJ_BODY   = 3'b010;
  localparam obj_code_t OBJ_APPLE  = 3'b011;
  localparam obj_code_t OBJ_BORDER = 3'b100;

endpackage

// File: rtl/frame_scan_counter.sv
// Raster x/y counter over the game grid, advancing one cell per enabled clock.
// With FRAME_DONE_EN defined it also emits a one-cycle pulse on the frame wrap.
module frame_scan_counter #(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 12,
  parameter int COORD_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
`ifdef FRAME_DONE_EN
  output logic               frame_done,
`endif
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  logic last_col;
  logic last_row;

  assign last_col = (x == COORD_W'(GRID_W - 1));
  assign last_row = (y == COORD_W'(GRID_H - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the statements are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (enable) begin
      if (last_col) begin
        x <= '0;
        y <= last_row ? '0 : y + COORD_W'(1);
      end else begin
        x <= x + COORD_W'(1);
      end
    end
  end

`ifdef FRAME_DONE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= enable && last_col && last_row;
    end
  end
`endif

endmodule

// File: rtl/frame_tracker.sv
// Scans the game grid, encodes each cell's object flags and flags cells whose
// code changed since the previous frame. Optional FRAME_DONE_EN adds frame_done.
module frame_tracker
  import frame_tracker_pkg::*;
#(
  parameter int GRID_W  = DEFAULT_GRID_W,
  parameter int GRID_H  = DEFAULT_GRID_H,
  parameter int COORD_W = DEFAULT_COORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               head,
  input  logic               body,
  input  logic               apple,
  input  logic               border,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
`ifdef FRAME_DONE_EN
  output logic               frame_done,
`endif
  output obj_code_t          obj_code,
  output logic               diff
);

  localparam int CELLS  = GRID_W * GRID_H;
  localparam int ADDR_W = $clog2(CELLS);

  obj_code_t         code;
  logic [ADDR_W-1:0] addr;
  obj_code_t         mem [CELLS];

  frame_scan_counter #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .COORD_W(COORD_W)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
`ifdef FRAME_DONE_EN
    .frame_done(frame_done),
`endif
    .x         (x),
    .y         (y)
  );

  // NOTE: the default assignment first guarantees every path drives code,
  // so no latch is inferred even if a branch is later edited away.
  always_comb begin
    code = OBJ_EMPTY;
    if (head) begin
      code = OBJ_HEAD;
    end else if (body) begin
      code = OBJ_BODY;
    end else if (apple) begin
      code = OBJ_APPLE;
    end else if (border) begin
      code = OBJ_BORDER;
    end
  end

  assign addr = ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);

  always_ff @(posedge clk) begin
    if (rst) begin
      obj_code <= OBJ_EMPTY;
      diff     <= 1'b0;
    end else if (enable) begin
      obj_code <= code;
      diff     <= (code != mem[addr]);
    end
  end

  // NOTE: this memory is a flop array with reset on purpose: the whole
  // previous frame must read as empty on the cycle right after reset, which
  // a RAM macro cannot provide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) begin
        mem[i] <= OBJ_EMPTY;
      end
    end else if (enable) begin
      mem[addr] <= code;
    end
  end

endmodule

// File: tb/tb_frame_tracker.sv
// Self-checking bench for frame_tracker: a frame-level reference model plus
// a priority table, directed scenes and randomized stimulus.
module tb_frame_tracker;

  localparam int W     = 16;
  localparam int H     = 12;
  localparam int CELLS = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       head = 1'b0, body = 1'b0, apple = 1'b0, border = 1'b0;
  logic [3:0] x, y;
  logic [2:0] obj_code;
  logic       diff;
`ifdef FRAME_DONE_EN
  logic       frame_done;
`endif

  frame_tracker dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .head      (head),
    .body      (body),
    .apple     (apple),
    .border    (border),
    .x         (x),
    .y         (y),
`ifdef FRAME_DONE_EN
    .frame_done(frame_done),
`endif
    .obj_code  (obj_code),
    .diff      (diff)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model: cell index n (0..191) and the previous-frame code of each cell.
  int         n;
  logic [2:0] mem_m [CELLS];
  logic [2:0] exp_code;
  logic       exp_diff;
  logic       exp_fd;
  int         fd_count;

  typedef struct {
    logic [3:0] flags;  // {head, body, apple, border}
    logic [2:0] code;
  } vec_t;

  vec_t prio_tbl [8];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_code(input logic [3:0] f);
    if (f[3]) return 3'b001;
    if (f[2]) return 3'b010;
    if (f[1]) return 3'b011;
    if (f[0]) return 3'b100;
    return 3'b000;
  endfunction

  // kind 0 = empty grid, 1 = frame A, 2 = frame B
  function automatic logic [3:0] scene(input int kind, input int cx, input int cy);
    logic h, b, a, bo;
    h  = 1'b0;
    b  = 1'b0;
    a  = 1'b0;
    bo = (kind != 0) && (cx == 0 || cx == W - 1 || cy == 0 || cy == H - 1);
    if (kind == 1) begin
      h = (cx == 4 && cy == 4);
      a = (cx == 6 && cy == 4);
    end else if (kind == 2) begin
      h = (cx == 5 && cy == 4);
      b = (cx == 4 && cy == 4);
      a = (cx == 7 && cy == 4);
    end
    return {h, b, a, bo};
  endfunction

  task automatic compare_outputs();
    check("x", int'(x), n % W);
    check("y", int'(y), n / W);
    check("obj_code", int'(obj_code), int'(exp_code));
    check("diff", int'(diff), int'(exp_diff));
`ifdef FRAME_DONE_EN
    check("frame_done", int'(frame_done), int'(exp_fd));
    if (frame_done) fd_count++;
`endif
  endtask

  task automatic step(input logic en, input logic [3:0] f);
    logic [2:0] c;
    enable = en;
    {head, body, apple, border} = f;
    @(posedge clk);
    #1;
    if (en) begin
      c        = ref_code(f);
      exp_diff = (c != mem_m[n]);
      mem_m[n] = c;
      exp_code = c;
      exp_fd   = (n == CELLS - 1);
      n        = (n + 1) % CELLS;
    end else begin
      exp_fd = 1'b0;
    end
    compare_outputs();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b1;
    {head, body, apple, border} = $urandom_range(15, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < CELLS; i++) mem_m[i] = 3'b000;
    exp_code = 3'b000;
    exp_diff = 1'b0;
    exp_fd   = 1'b0;
    check("reset_x", int'(x), 0);
    check("reset_y", int'(y), 0);
    check("reset_code", int'(obj_code), 0);
    check("reset_diff", int'(diff), 0);
  endtask

  task automatic run_frame(input int kind, output int diffs);
    diffs = 0;
    for (int i = 0; i < CELLS; i++) begin
      step(1'b1, scene(kind, n % W, n / W));
      if (diff) diffs++;
    end
  endtask

  initial begin
    int diffs;

    prio_tbl[0] = '{4'b1111, 3'b001};
    prio_tbl[1] = '{4'b1000, 3'b001};
    prio_tbl[2] = '{4'b0111, 3'b010};
    prio_tbl[3] = '{4'b0100, 3'b010};
    prio_tbl[4] = '{4'b0011, 3'b011};
    prio_tbl[5] = '{4'b0010, 3'b011};
    prio_tbl[6] = '{4'b0001, 3'b100};
    prio_tbl[7] = '{4'b0000, 3'b000};

    do_reset();

    // Empty frame with explicit scan-wrap checks.
    fd_count = 0;
    for (int i = 0; i < CELLS; i++) begin
      step(1'b1, 4'b0000);
      if (i == W - 1) begin
        check("wrap_row_x", int'(x), 0);
        check("wrap_row_y", int'(y), 1);
      end
      if (i == CELLS - 1) begin
        check("wrap_frame_x", int'(x), 0);
        check("wrap_frame_y", int'(y), 0);
      end
    end
`ifdef FRAME_DONE_EN
    check("frame_done_pulses", fd_count, 1);
`endif

    // Frame A: 52 border cells + head + apple change from empty.
    run_frame(1, diffs);
    check("frameA_diffs", diffs, 54);

    // Frame B: only (4,4), (5,4), (6,4), (7,4) change.
    run_frame(2, diffs);
    check("frameB_diffs", diffs, 4);

    // Enable low mid-frame with toggling flags: everything holds.
    for (int i = 0; i < 37; i++) step(1'b1, scene(2, n % W, n / W));
    for (int i = 0; i < 10; i++) step(1'b0, 4'($urandom_range(15, 0)));
    check("freeze_resume_x", int'(x), 37 % W);
    for (int i = 0; i < 5; i++) step(1'b1, scene(2, n % W, n / W));

    // Priority table.
    foreach (prio_tbl[i]) begin
      step(1'b1, prio_tbl[i].flags);
      check("prio_code", int'(obj_code), int'(prio_tbl[i].code));
    end

    // Randomized stimulus over several frames.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(3, 0) != 0), 4'($urandom_range(15, 0)));
    end

    // Reset mid-frame, then frame A flags every non-empty cell again.
    for (int i = 0; i < 23; i++) step(1'b1, 4'($urandom_range(15, 0)));
    do_reset();
    run_frame(1, diffs);
    check("frameA_after_reset_diffs", diffs, 54);
    run_frame(1, diffs);
    check("frameA_repeat_diffs", diffs, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/frame_tracker.md
Name: frame_tracker

Overview:
- Raster-scans a 16x12 game grid, one cell per enabled clock, presenting the current cell coordinate on x/y.
- Encodes the object flags for that cell (head/body/apple/border) into a 3-bit object code.
- Keeps a one-frame cell memory and flags any cell whose code differs from the previous frame.
- Sits between the game-state logic (which answers "what is at x,y") and the display/redraw logic (which only repaints changed cells).

Parameters:
- GRID_W, 16, number of columns; x range 0..GRID_W-1.
- GRID_H, 12, number of rows; y range 0..GRID_H-1.
- COORD_W, 4, width of the x and y ports.
- CODE_W, 3, width of obj_code.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when high, process the current cell and advance the scan.
- head  in  1  current cell holds the snake head.
- body  in  1  current cell holds a snake body segment.
- apple  in  1  current cell holds the apple.
- border  in  1  current cell is a border wall.
- x  out  COORD_W  column of the cell being sampled this cycle (registered).
- y  out  COORD_W  row of the cell being sampled this cycle (registered).
- obj_code  out  CODE_W  registered code of the last processed cell.
- diff  out  1  registered: last processed cell's code differs from its code in the previous frame.

Behaviour:
- Encoding, combinational, priority head > body > apple > border > empty:
  - head = 3'b001; body = 3'b010; apple = 3'b011; border = 3'b100; none = 3'b000.
  - Codes 101..111 are never produced.
- Scan order: x increments fastest; at x = GRID_W-1, x wraps to 0 and y increments; at (GRID_W-1, GRID_H-1) both wrap to 0.
  - One frame = 192 enabled cycles.
- Per rising edge with rst = 0 and enable = 1, for the cell at the current (x,y) with code c:
  - obj_code <= c.
  - diff <= (c != mem[y][x]).
  - mem[y][x] <= c.
  - x/y advance to the next cell.
- The upstream logic drives the flags combinationally from x/y in the same cycle.
- Latency: obj_code and diff describe the cell at (x,y) one cycle after sampling.
- enable = 0: x, y, obj_code, diff and the memory all hold their values; the flag inputs are ignored.
- Reset (rst = 1 at a clock edge, with priority over enable), applicable mid-frame:
  - x = 0, y = 0, obj_code = 000, diff = 0.
  - All 192 memory entries cleared to 000 in that same cycle.
  - The first frame after reset therefore asserts diff only for non-empty cells.
- Simultaneous flags resolve by priority and are not an error.
- diff is a per-cell flag valid alongside obj_code; it is not sticky.
- Memory: 192 entries x 3 bits, implemented as a flop array so the single-cycle reset clear is possible.
  - Indexed by y*GRID_W + x.

Optional Feature:
- Macro FRAME_DONE_EN.
- When defined: extra output frame_done (1 bit, registered, reset 0).
  - Pulses high for exactly one cycle on the edge where an enabled cycle processes cell (15,11) and the scan wraps to (0,0).
  - Low otherwise, including while enable = 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package frame_tracker_pkg holds:
  - the object code constants OBJ_EMPTY, OBJ_HEAD, OBJ_BODY, OBJ_APPLE, OBJ_BORDER;
  - a typedef obj_code_t (logic [2:0]);
  - GRID_W/GRID_H defaults.
- One natural sub-module, frame_scan_counter: the x/y raster counter with enable, wrap and (optional) frame-done pulse.
- Encoder, memory and compare stay in frame_tracker.

Test Plan:
- Reset, then enable = 1 with all flags 0 for 100 cycles -> obj_code = 000, diff = 0 throughout; x/y advance 0..15 then the row steps.
- Frame A: head at (4,4), apple at (6,4), border on rows 0/11 and columns 0/15 -> each cell's obj_code matches its encoding one cycle later; diff = 1 exactly on the non-empty cells (head 001, apple 011, border 100).
- Frame B, the next 192 cycles: head (5,4), body (4,4), apple (7,4), border unchanged:
  - diff = 1 at (4,4) (001->010), (5,4) (000->001), (6,4) (011->000), (7,4) (000->011);
  - diff = 0 on every border cell and on all other cells.
- Scan wrap: from reset, after 16 enabled cycles x = 0, y = 1; after 192 cycles x = 0, y = 0. With FRAME_DONE_EN, frame_done pulses once at the 192nd cycle.
- enable = 0 for 10 cycles mid-frame, with flags toggling -> x, y, obj_code and diff stay frozen; the scan resumes at the same cell.
- Priority and reset: head = body = apple = border = 1 -> obj_code = 001. rst asserted mid-frame -> next cycle x = y = 0, obj_code = 000, diff = 0; a repeat of frame A shows diff = 1 on all non-empty cells.
